// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : shared types for the generic pipeline stage register.  Rev 1.0
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  // RV32I addi x0,x0,0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Instruction sits in the LSBs so a zero-extended RV_NOP is a valid bubble.
  typedef struct packed {
    logic [31:0] ctrl;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [15:0] ctrl;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rs2_val;
    logic [31:0] rs1_val;
    logic [31:0] pc;
    logic [31:0] instr;
  } id_ex_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : saturating up-counter with synchronous clear.  Rev 1.0
// ============================================================================
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// pipe_stage_skid : valid/ready pipeline register with 2-entry skid and flush.
// Optional PIPE_STAT_EN adds saturating stall/flush counters.  Rev 1.0
// ============================================================================
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned          PAYLOAD_W = 96,
  parameter logic [PAYLOAD_W-1:0] NOP_VAL   = PAYLOAD_W'(RV_NOP),
  parameter int unsigned          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  skid_state_t          state_q, state_d;
  logic [PAYLOAD_W-1:0] m_data_q, m_data_d;
  logic [PAYLOAD_W-1:0] s_data_q, s_data_d;

  logic m_valid;
  logic s_valid;
  logic fire_in;
  logic fire_out;

  assign m_valid  = (state_q == ST_BUSY) || (state_q == ST_FULL);
  assign s_valid  = (state_q == ST_FULL);
  // Register decode only: back-pressure never sees out_ready combinationally.
  assign in_ready = !s_valid;
  assign fire_in  = in_valid && in_ready;
  assign fire_out = m_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    if (flush) begin
      state_d  = ST_EMPTY;
      m_data_d = NOP_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (fire_in) begin
            state_d  = ST_BUSY;
            m_data_d = in_data;
          end
        end
        ST_BUSY: begin
          if (fire_in && !fire_out) begin
            state_d  = ST_FULL;
            s_data_d = in_data;
          end else if (fire_in && fire_out) begin
            m_data_d = in_data;
          end else if (fire_out) begin
            state_d  = ST_EMPTY;
            m_data_d = NOP_VAL;
          end
        end
        ST_FULL: begin
          if (fire_out) begin
            state_d  = ST_BUSY;
            m_data_d = s_data_q;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          m_data_d = NOP_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      m_data_q <= NOP_VAL;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
    end
    s_data_q <= s_data_d;
  end

  // A skid entry without a main entry is unrepresentable; catch corruption.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (state_q == ST_EMPTY || state_q == ST_BUSY || state_q == ST_FULL);
    end
  end

  assign out_valid = m_valid;
  assign out_data  = m_data_q;

`ifdef PIPE_STAT_EN
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (m_valid && !out_ready && !flush),
    .cnt (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (flush && (m_valid || s_valid)),
    .cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule : pipe_stage_skid
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_skid : directed self-checking bench for pipe_stage_skid. Rev 1.0
// ============================================================================
module tb_pipe_stage_skid;

  localparam int unsigned PW = 96;
  localparam int unsigned CW = 4;
`ifdef PIPE_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PW-1:0] in_data, out_data;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_skid #(.PAYLOAD_W(PW), .NOP_VAL(96'h13), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] cexp(input int v);
    return STAT ? PW'(v) : '0;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 96'hA5; out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", PW'(out_valid), 96'd0);
    chk("rst_out_data",  out_data,        96'h13);
    chk("rst_in_ready",  PW'(in_ready),   96'd1);
    chk("rst_stall_cnt", PW'(stall_cnt),  96'd0);
    chk("rst_flush_cnt", PW'(flush_cnt),  96'd0);

    // streaming at full rate
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = PW'(k);
      step();
      chk($sformatf("stream_data_%0d", k), out_data, PW'(k));
      chk($sformatf("stream_rdy_%0d", k),  PW'(in_ready), 96'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_valid", PW'(out_valid), 96'd0);
    chk("stream_drain_bubble", out_data, 96'h13);

    // back-pressure
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 96'd1;
    step();
    chk("bp_busy_data", out_data, 96'd1);
    chk("bp_busy_rdy",  PW'(in_ready), 96'd1);
    in_data = 96'd2;
    step();
    chk("bp_full_rdy",  PW'(in_ready), 96'd0);
    in_data = 96'd3;
    step();
    chk("bp_held_data", out_data, 96'd1);
    chk("bp_held_rdy",  PW'(in_ready), 96'd0);
    chk("bp_stall_cnt", PW'(stall_cnt), cexp(2));
    out_ready = 1'b1;
    step();
    chk("bp_out2", out_data, 96'd2);
    chk("bp_out2_rdy", PW'(in_ready), 96'd1);
    step();
    chk("bp_out3", out_data, 96'd3);
    in_valid = 1'b0;
    step();
    chk("bp_empty_valid", PW'(out_valid), 96'd0);
    chk("bp_stall_final", PW'(stall_cnt), cexp(2));

    // flush while FULL holding 4,5 with beat 6 presented
    out_ready = 1'b0; in_valid = 1'b1; in_data = 96'd4;
    step();
    in_data = 96'd5;
    step();
    chk("fl_full_data", out_data, 96'd4);
    chk("fl_full_rdy",  PW'(in_ready), 96'd0);
    in_data = 96'd6; flush = 1'b1;
    step();
    chk("fl_valid",  PW'(out_valid), 96'd0);
    chk("fl_bubble", out_data, 96'h13);
    chk("fl_rdy",    PW'(in_ready), 96'd1);
    chk("fl_cnt",    PW'(flush_cnt), cexp(1));
    chk("fl_stall",  PW'(stall_cnt), cexp(3));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("fl_no_beat6", PW'(out_valid), 96'd0);

    // flush while EMPTY leaves flush_cnt alone
    flush = 1'b1;
    step();
    chk("fl_empty_valid", PW'(out_valid), 96'd0);
    chk("fl_empty_cnt",   PW'(flush_cnt), cexp(1));

    // flush and reset together while BUSY
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 96'd7;
    step();
    chk("frst_busy", out_data, 96'd7);
    in_valid = 1'b0; flush = 1'b1; rst = 1'b1;
    step();
    chk("frst_valid", PW'(out_valid), 96'd0);
    chk("frst_data",  out_data, 96'h13);
    chk("frst_rdy",   PW'(in_ready), 96'd1);
    chk("frst_fcnt",  PW'(flush_cnt), 96'd0);
    chk("frst_scnt",  PW'(stall_cnt), 96'd0);

    // stall counter saturation
    flush = 1'b0; rst = 1'b0; in_valid = 1'b1; in_data = 96'd9;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("sat_data",  out_data, 96'd9);
    chk("sat_stall", PW'(stall_cnt), cexp(15));
    out_ready = 1'b1;
    step();
    chk("sat_drain", PW'(out_valid), 96'd0);
    chk("sat_hold",  PW'(stall_cnt), cexp(15));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pipe_stage_skid
`default_nettype wire
